// File: rtl/ov7670_sccb_config_sequencer_if.sv
// Byte-level SCCB controller handshake: transaction descriptor plus GO/END/ACK.
// The master side (sequencer) drives the request; the slave side (controller)
// answers with END, ACK and the read byte.
interface ov7670_sccb_config_sequencer_if;
  logic [23:0] oI2C_DATA;   // {slave addr, reg, value}
  logic        oI2C_RD;     // 1 = read transaction
  logic        oI2C_GO;     // one-cycle start pulse
  logic        iI2C_END;    // one-cycle completion pulse
  logic        iI2C_ACK;    // valid with END: all bytes acknowledged
  logic [7:0]  iI2C_RDATA;  // valid with END on reads

  modport master (
    output oI2C_DATA, oI2C_RD, oI2C_GO,
    input  iI2C_END, iI2C_ACK, iI2C_RDATA
  );

  modport slave (
    input  oI2C_DATA, oI2C_RD, oI2C_GO,
    output iI2C_END, iI2C_ACK, iI2C_RDATA
  );
endinterface

// File: rtl/ov7670_sccb_config_sequencer.sv
// OV7670 configuration sequencer: walks the register LUT and issues one SCCB
// transaction per entry. Leading entries are ID reads compared against the
// stored value; the rest are register writes. Handles power-up delay, NACK
// retry and the extra settle time after a soft reset (reg 0x12, bit7 set).
//
// state      | meaning
// -----------+---------------------------------------------------------------
// PWR_WAIT   | power-up delay after reset / re-init
// FETCH      | latch LUT entry into the transaction descriptor
// ISSUE      | GO pulse to the SCCB controller
// WAIT_END   | transaction outstanding, waiting for END
// GAP_WAIT   | inter-transaction idle (extended after soft reset)
// DONE       | every entry written, CONFIG_DONE high
// FAIL       | retries exhausted on ERR_INDEX
module ov7670_sccb_config_sequencer #(
  parameter int unsigned LUT_SIZE       = 167,
  parameter int unsigned READ_COUNT     = 2,
  parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
  parameter logic [19:0] POWERUP_CYCLES = 20'd1_000_000,
  parameter logic [19:0] SWRST_CYCLES   = 20'd50_000,
  parameter logic [9:0]  GAP_CYCLES     = 10'd500,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                                  iCLK,
  input  logic                                  iRST,
  input  logic                                  iREINIT,
  output logic [7:0]                            oLUT_INDEX,
  input  logic [15:0]                           iLUT_DATA,
  ov7670_sccb_config_sequencer_if.master        i2c,
  output logic                                  oCONFIG_DONE,
  output logic                                  oID_OK,
  output logic                                  oERR,
  output logic [7:0]                            oERR_INDEX
);

  // One spare bit over the 20-bit delays so GAP+SWRST and POWERUP+1 never wrap.
  localparam int CNT_W = 21;
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES) - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES) - CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(GAP_CYCLES) + CNT_W'(SWRST_CYCLES)
                                           - CNT_W'(1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [7:0]       LAST_IDX  = 8'(LUT_SIZE - 1);
  localparam logic [8:0]       RD_LIM    = 9'(READ_COUNT);
  localparam logic [7:0]       SWRST_REG = 8'h12;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_END,
    S_GAP_WAIT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RTY_W-1:0] retry_cnt_q;
  logic             retry_pend_q;
  logic             swrst_q;
  logic [7:0]       lut_index_q;
  logic [23:0]      i2c_data_q;
  logic             rd_q;
  logic             go_q;
  logic             config_done_q;
  logic             id_ok_q;
  logic             err_q;
  logic [7:0]       err_index_q;

  logic             is_read_d;
  logic             rdata_mismatch_d;
  logic             swrst_hit_d;
  logic             retry_avail_d;
  logic [CNT_W-1:0] gap_last_d;

  // Entry classification and the terminal count for the current gap.
  always_comb begin
    is_read_d        = ({1'b0, lut_index_q} < RD_LIM);
    rdata_mismatch_d = (i2c.iI2C_RDATA != i2c_data_q[7:0]);
    swrst_hit_d      = !rd_q && (i2c_data_q[15:8] == SWRST_REG) && i2c_data_q[7];
    retry_avail_d    = (retry_cnt_q < RTY_MAX);
    gap_last_d       = swrst_q ? LONG_LAST : GAP_LAST;
  end

  // Sequencer FSM; all outputs are registered here.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q       <= S_PWR_WAIT;
      cnt_q         <= '0;
      retry_cnt_q   <= '0;
      retry_pend_q  <= 1'b0;
      swrst_q       <= 1'b0;
      lut_index_q   <= '0;
      i2c_data_q    <= '0;
      rd_q          <= 1'b0;
      go_q          <= 1'b0;
      config_done_q <= 1'b0;
      id_ok_q       <= 1'b1;
      err_q         <= 1'b0;
      err_index_q   <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        S_PWR_WAIT: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q   <= '0;
            state_q <= S_FETCH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_FETCH: begin
          // LUT is combinational on the index, so its output is valid now.
          i2c_data_q <= {SLAVE_ADDR | {7'd0, is_read_d}, iLUT_DATA};
          rd_q       <= is_read_d;
          go_q       <= 1'b1;
          state_q    <= S_ISSUE;
        end

        S_ISSUE: begin
          state_q <= S_WAIT_END;
        end

        S_WAIT_END: begin
          if (i2c.iI2C_END) begin
            if (i2c.iI2C_ACK) begin
              // ID mismatch is recorded but does not stop configuration.
              if (rd_q && rdata_mismatch_d) begin
                id_ok_q <= 1'b0;
              end
              retry_cnt_q  <= '0;
              retry_pend_q <= 1'b0;
              swrst_q      <= swrst_hit_d;
              cnt_q        <= '0;
              state_q      <= S_GAP_WAIT;
            end else if (retry_avail_d) begin
              retry_cnt_q  <= retry_cnt_q + RTY_W'(1);
              retry_pend_q <= 1'b1;
              swrst_q      <= 1'b0;
              cnt_q        <= '0;
              state_q      <= S_GAP_WAIT;
            end else begin
              err_q       <= 1'b1;
              err_index_q <= lut_index_q;
              state_q     <= S_FAIL;
            end
          end
        end

        S_GAP_WAIT: begin
          if (cnt_q == gap_last_d) begin
            cnt_q   <= '0;
            swrst_q <= 1'b0;
            if (retry_pend_q) begin
              retry_pend_q <= 1'b0;
              state_q      <= S_FETCH;
            end else if (lut_index_q == LAST_IDX) begin
              config_done_q <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              lut_index_q <= lut_index_q + 8'd1;
              state_q     <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DONE, S_FAIL: begin
          if (iREINIT) begin
            config_done_q <= 1'b0;
            err_q         <= 1'b0;
            err_index_q   <= '0;
            lut_index_q   <= '0;
            retry_cnt_q   <= '0;
            retry_pend_q  <= 1'b0;
            swrst_q       <= 1'b0;
            id_ok_q       <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_PWR_WAIT;
          end
        end

        default: begin
          state_q <= S_PWR_WAIT;
        end
      endcase
    end
  end

  assign oLUT_INDEX    = lut_index_q;
  assign i2c.oI2C_DATA = i2c_data_q;
  assign i2c.oI2C_RD   = rd_q;
  assign i2c.oI2C_GO   = go_q;
  assign oCONFIG_DONE  = config_done_q;
  assign oID_OK        = id_ok_q;
  assign oERR          = err_q;
  assign oERR_INDEX    = err_index_q;

endmodule

// File: tb/tb_ov7670_sccb_config_sequencer.sv
// Directed bench for the OV7670 configuration sequencer with a behavioural
// SCCB controller (END a fixed delay after GO) and a small LUT model.
module tb_ov7670_sccb_config_sequencer;
  localparam int          LUT_SIZE = 167;
  localparam int          END_DLY  = 20;
  localparam logic [19:0] PWR      = 20'd40;
  localparam logic [19:0] SWRST    = 20'd200;
  localparam logic [9:0]  GAP      = 10'd10;
  // GO-to-GO spacing: END after END_DLY cycles, 1 cycle to leave WAIT_END,
  // GAP cycles, FETCH, ISSUE.
  localparam int          SPACE    = END_DLY + 2 + 10;
  localparam int          LONG     = SPACE + 200;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iREINIT = 1'b0;
  logic [7:0] oLUT_INDEX;
  logic [15:0] iLUT_DATA;
  logic       oCONFIG_DONE, oID_OK, oERR;
  logic [7:0] oERR_INDEX;

  ov7670_sccb_config_sequencer_if bus ();

  ov7670_sccb_config_sequencer #(
    .LUT_SIZE(LUT_SIZE), .READ_COUNT(2), .SLAVE_ADDR(8'h42),
    .POWERUP_CYCLES(PWR), .SWRST_CYCLES(SWRST), .GAP_CYCLES(GAP), .MAX_RETRY(3)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iREINIT(iREINIT),
    .oLUT_INDEX(oLUT_INDEX), .iLUT_DATA(iLUT_DATA),
    .i2c(bus),
    .oCONFIG_DONE(oCONFIG_DONE), .oID_OK(oID_OK), .oERR(oERR), .oERR_INDEX(oERR_INDEX)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc++;

  int vectors = 0;
  int miscompares = 0;

  bit       swrst_en = 0;
  logic [7:0] rd0_val = 8'h76;
  int       nack_idx = -1;
  int       nack_left = 0;   // 255 = NACK forever

  function automatic logic [15:0] lut_fn(input logic [7:0] i, input bit sw);
    if (i == 8'd0)            return 16'h0A76;
    if (i == 8'd1)            return 16'h0B73;
    if (i == 8'd4 && sw)      return 16'h1280;
    if (i == 8'd100)          return 16'h0000;
    return {i, i ^ 8'h5A};
  endfunction

  function automatic logic [23:0] exp_data(input int i, input bit sw);
    logic [7:0] a;
    a = (i < 2) ? 8'h43 : 8'h42;
    return {a, lut_fn(8'(i), sw)};
  endfunction

  always_comb iLUT_DATA = lut_fn(oLUT_INDEX, swrst_en);

  // GO log
  int          go_idx [512];
  logic [23:0] go_data[512];
  bit          go_rd  [512];
  int          go_time[512];
  int          go_n = 0;
  int          rst_rel = 0;

  // Behavioural SCCB controller, acting on the falling edge.
  int countdown = 0;
  int cur_idx = 0;
  always @(negedge iCLK) begin
    bus.iI2C_END = 1'b0;
    if (bus.oI2C_GO === 1'b1) begin
      if (go_n < 512) begin
        go_idx[go_n]  = int'(oLUT_INDEX);
        go_data[go_n] = bus.oI2C_DATA;
        go_rd[go_n]   = bus.oI2C_RD;
        go_time[go_n] = cyc;
      end
      go_n++;
      cur_idx = int'(oLUT_INDEX);
      countdown = END_DLY;
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        bus.iI2C_END = 1'b1;
        if (cur_idx == nack_idx && nack_left > 0) begin
          bus.iI2C_ACK = 1'b0;
          if (nack_left != 255) nack_left--;
        end else begin
          bus.iI2C_ACK = 1'b1;
        end
        bus.iI2C_RDATA = (cur_idx == 0) ? rd0_val : (cur_idx == 1) ? 8'h73 : 8'h00;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #2;
  endtask

  task automatic apply_reset();
    iRST = 1'b1;
    iREINIT = 1'b0;
    tick(3);
    go_n = 0;
    iRST = 1'b0;
    rst_rel = cyc;
  endtask

  task automatic wait_finish(input int maxc);
    int n = 0;
    while (!(oCONFIG_DONE || oERR) && n < maxc) begin
      tick(1);
      n++;
    end
    vectors++;
    if (!(oCONFIG_DONE || oERR)) begin
      miscompares++;
      $display("FAIL finish_timeout: done=%b err=%b go_n=%0d, required done/err within %0d cycles",
               oCONFIG_DONE, oERR, go_n, maxc);
    end
  endtask

  task automatic wait_go(input int cnt, input int maxc);
    int n = 0;
    while (go_n < cnt && n < maxc) begin
      tick(1);
      n++;
    end
    vectors++;
    if (go_n < cnt) begin
      miscompares++;
      $display("FAIL go_timeout: go_n=%0d, required %0d within %0d cycles", go_n, cnt, maxc);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    tick(3);
    vectors += 8;
    if (oLUT_INDEX !== 8'd0)   begin miscompares++; $display("FAIL rst_index: got %h want 00", oLUT_INDEX); end
    if (bus.oI2C_DATA !== 24'd0) begin miscompares++; $display("FAIL rst_data: got %h want 000000", bus.oI2C_DATA); end
    if (bus.oI2C_RD !== 1'b0)  begin miscompares++; $display("FAIL rst_rd: got %b want 0", bus.oI2C_RD); end
    if (bus.oI2C_GO !== 1'b0)  begin miscompares++; $display("FAIL rst_go: got %b want 0", bus.oI2C_GO); end
    if (oCONFIG_DONE !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", oCONFIG_DONE); end
    if (oID_OK !== 1'b1)       begin miscompares++; $display("FAIL rst_id_ok: got %b want 1", oID_OK); end
    if (oERR !== 1'b0)         begin miscompares++; $display("FAIL rst_err: got %b want 0", oERR); end
    if (oERR_INDEX !== 8'd0)   begin miscompares++; $display("FAIL rst_err_index: got %h want 00", oERR_INDEX); end
  endtask

  task automatic test_full_sequence();
    swrst_en = 0; nack_idx = -1; nack_left = 0; rd0_val = 8'h76;
    apply_reset();
    wait_go(1, 200);
    vectors++;
    if (go_time[0] - rst_rel < int'(PWR) || go_time[0] - rst_rel > int'(PWR) + 2) begin
      miscompares++;
      $display("FAIL powerup_delay: got %0d cycles want %0d..%0d", go_time[0] - rst_rel, PWR, PWR + 2);
    end
    // REINIT mid-run must be ignored.
    wait_go(50, 3000);
    iREINIT = 1'b1;
    tick(1);
    iREINIT = 1'b0;
    wait_finish(8000);
    tick(50);
    vectors += 5;
    if (go_n !== LUT_SIZE)     begin miscompares++; $display("FAIL full_go_count: got %0d want %0d", go_n, LUT_SIZE); end
    if (oCONFIG_DONE !== 1'b1) begin miscompares++; $display("FAIL full_done: got %b want 1", oCONFIG_DONE); end
    if (oERR !== 1'b0)         begin miscompares++; $display("FAIL full_err: got %b want 0", oERR); end
    if (oID_OK !== 1'b1)       begin miscompares++; $display("FAIL full_id_ok: got %b want 1", oID_OK); end
    if (go_time[5] - go_time[4] !== SPACE) begin
      miscompares++; $display("FAIL full_spacing_4: got %0d want %0d", go_time[5] - go_time[4], SPACE);
    end
    for (int i = 0; i < LUT_SIZE && i < go_n; i++) begin
      vectors += 3;
      if (go_idx[i] !== i) begin
        miscompares++; $display("FAIL full_idx[%0d]: got %0d want %0d", i, go_idx[i], i);
      end
      if (go_rd[i] !== (i < 2)) begin
        miscompares++; $display("FAIL full_rd[%0d]: got %b want %b", i, go_rd[i], (i < 2));
      end
      if (go_data[i] !== exp_data(i, 1'b0)) begin
        miscompares++; $display("FAIL full_data[%0d]: got %h want %h", i, go_data[i], exp_data(i, 1'b0));
      end
    end
  endtask

  task automatic test_id_mismatch();
    rd0_val = 8'h77;
    apply_reset();
    wait_finish(8000);
    vectors += 4;
    if (oID_OK !== 1'b0)       begin miscompares++; $display("FAIL idmm_id_ok: got %b want 0", oID_OK); end
    if (oCONFIG_DONE !== 1'b1) begin miscompares++; $display("FAIL idmm_done: got %b want 1", oCONFIG_DONE); end
    if (oERR !== 1'b0)         begin miscompares++; $display("FAIL idmm_err: got %b want 0", oERR); end
    if (go_n !== LUT_SIZE)     begin miscompares++; $display("FAIL idmm_go_count: got %0d want %0d", go_n, LUT_SIZE); end
    rd0_val = 8'h76;
    iREINIT = 1'b1;
    tick(1);
    iREINIT = 1'b0;
    vectors += 2;
    if (oID_OK !== 1'b1)       begin miscompares++; $display("FAIL idmm_reinit_id_ok: got %b want 1", oID_OK); end
    if (oCONFIG_DONE !== 1'b0) begin miscompares++; $display("FAIL idmm_reinit_done: got %b want 0", oCONFIG_DONE); end
  endtask

  task automatic test_nack_retry();
    nack_idx = 5; nack_left = 2;
    apply_reset();
    wait_finish(8000);
    vectors += 8;
    if (go_n !== LUT_SIZE + 2) begin miscompares++; $display("FAIL retry_go_count: got %0d want %0d", go_n, LUT_SIZE + 2); end
    if (oERR !== 1'b0)         begin miscompares++; $display("FAIL retry_err: got %b want 0", oERR); end
    if (oCONFIG_DONE !== 1'b1) begin miscompares++; $display("FAIL retry_done: got %b want 1", oCONFIG_DONE); end
    if (go_idx[6] !== 5 || go_idx[7] !== 5) begin
      miscompares++; $display("FAIL retry_reissue_idx: got %0d,%0d want 5,5", go_idx[6], go_idx[7]);
    end
    if (go_data[6] !== exp_data(5, 1'b0) || go_data[7] !== exp_data(5, 1'b0)) begin
      miscompares++; $display("FAIL retry_reissue_data: got %h,%h want %h", go_data[6], go_data[7], exp_data(5, 1'b0));
    end
    if (go_data[5] !== exp_data(5, 1'b0)) begin
      miscompares++; $display("FAIL retry_first_data: got %h want %h", go_data[5], exp_data(5, 1'b0));
    end
    if (go_idx[8] !== 6) begin miscompares++; $display("FAIL retry_next_idx: got %0d want 6", go_idx[8]); end
    if (go_time[6] - go_time[5] !== SPACE) begin
      miscompares++; $display("FAIL retry_spacing: got %0d want %0d", go_time[6] - go_time[5], SPACE);
    end
    nack_idx = -1; nack_left = 0;
  endtask

  task automatic test_retry_exhaust();
    int reinit_cyc;
    nack_idx = 9; nack_left = 255;
    apply_reset();
    wait_finish(2000);
    tick(200);
    vectors += 5;
    if (oERR !== 1'b1)         begin miscompares++; $display("FAIL exh_err: got %b want 1", oERR); end
    if (oERR_INDEX !== 8'd9)   begin miscompares++; $display("FAIL exh_err_index: got %0d want 9", oERR_INDEX); end
    if (oCONFIG_DONE !== 1'b0) begin miscompares++; $display("FAIL exh_done: got %b want 0", oCONFIG_DONE); end
    if (go_n !== 13)           begin miscompares++; $display("FAIL exh_go_count: got %0d want 13", go_n); end
    if (go_idx[9] !== 9 || go_idx[10] !== 9 || go_idx[11] !== 9 || go_idx[12] !== 9) begin
      miscompares++;
      $display("FAIL exh_attempt_idx: got %0d,%0d,%0d,%0d want 9,9,9,9", go_idx[9], go_idx[10], go_idx[11], go_idx[12]);
    end
    nack_idx = -1; nack_left = 0;
    iREINIT = 1'b1;
    reinit_cyc = cyc;
    tick(1);
    iREINIT = 1'b0;
    vectors += 3;
    if (oERR !== 1'b0)       begin miscompares++; $display("FAIL reinit_err: got %b want 0", oERR); end
    if (oERR_INDEX !== 8'd0) begin miscompares++; $display("FAIL reinit_err_index: got %0d want 0", oERR_INDEX); end
    if (oLUT_INDEX !== 8'd0) begin miscompares++; $display("FAIL reinit_index: got %0d want 0", oLUT_INDEX); end
    wait_go(14, 200);
    vectors += 2;
    if (go_idx[13] !== 0) begin miscompares++; $display("FAIL reinit_first_idx: got %0d want 0", go_idx[13]); end
    if (go_time[13] - reinit_cyc < int'(PWR) || go_time[13] - reinit_cyc > int'(PWR) + 3) begin
      miscompares++;
      $display("FAIL reinit_delay: got %0d cycles want %0d..%0d", go_time[13] - reinit_cyc, PWR, PWR + 3);
    end
  endtask

  task automatic test_swrst_settle();
    swrst_en = 1;
    apply_reset();
    wait_go(7, 2000);
    vectors += 4;
    if (go_data[4] !== 24'h421280) begin miscompares++; $display("FAIL swrst_data: got %h want 421280", go_data[4]); end
    if (go_time[4] - go_time[3] !== SPACE) begin
      miscompares++; $display("FAIL swrst_spacing_3: got %0d want %0d", go_time[4] - go_time[3], SPACE);
    end
    if (go_time[5] - go_time[4] !== LONG) begin
      miscompares++; $display("FAIL swrst_spacing_4: got %0d want %0d", go_time[5] - go_time[4], LONG);
    end
    if (go_time[6] - go_time[5] !== SPACE) begin
      miscompares++; $display("FAIL swrst_spacing_5: got %0d want %0d", go_time[6] - go_time[5], SPACE);
    end
    swrst_en = 0;
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    wait_go(41, 3000);
    tick(3);
    vectors++;
    if (go_idx[40] !== 40) begin miscompares++; $display("FAIL mid_issue_idx: got %0d want 40", go_idx[40]); end
    iRST = 1'b1;
    tick(1);
    vectors += 6;
    if (oLUT_INDEX !== 8'd0)     begin miscompares++; $display("FAIL mid_rst_index: got %0d want 0", oLUT_INDEX); end
    if (bus.oI2C_DATA !== 24'd0) begin miscompares++; $display("FAIL mid_rst_data: got %h want 000000", bus.oI2C_DATA); end
    if (bus.oI2C_RD !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_rd: got %b want 0", bus.oI2C_RD); end
    if (oID_OK !== 1'b1)         begin miscompares++; $display("FAIL mid_rst_id_ok: got %b want 1", oID_OK); end
    if (oERR !== 1'b0)           begin miscompares++; $display("FAIL mid_rst_err: got %b want 0", oERR); end
    if (oCONFIG_DONE !== 1'b0)   begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", oCONFIG_DONE); end
    iRST = 1'b0;
    rst_rel = cyc;
    // The stale END for index 40 lands during the power-up wait.
    tick(25);
    vectors += 2;
    if (oLUT_INDEX !== 8'd0) begin miscompares++; $display("FAIL mid_late_end_index: got %0d want 0", oLUT_INDEX); end
    if (go_n !== 41)         begin miscompares++; $display("FAIL mid_late_end_go: got %0d want 41", go_n); end
    wait_go(42, 200);
    vectors += 3;
    if (go_idx[41] !== 0) begin miscompares++; $display("FAIL mid_first_idx: got %0d want 0", go_idx[41]); end
    if (go_data[41] !== exp_data(0, 1'b0)) begin
      miscompares++; $display("FAIL mid_first_data: got %h want %h", go_data[41], exp_data(0, 1'b0));
    end
    if (go_time[41] - rst_rel < int'(PWR) || go_time[41] - rst_rel > int'(PWR) + 2) begin
      miscompares++;
      $display("FAIL mid_powerup_delay: got %0d cycles want %0d..%0d", go_time[41] - rst_rel, PWR, PWR + 2);
    end
  endtask

  initial begin
    bus.iI2C_END = 1'b0;
    bus.iI2C_ACK = 1'b0;
    bus.iI2C_RDATA = 8'h00;
    test_reset();
    test_full_sequence();
    test_id_mismatch();
    test_nack_retry();
    test_retry_exhaust();
    test_swrst_settle();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
